// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the 1101 serial pattern detector.
//   state_e : 2-bit FSM state encoding (S0 idle, S1 "1", S2 "11", S3 "110")
//   PATTERN : target bit pattern, oldest bit in the MSB
//   PAT_LEN : number of bits in PATTERN
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1101;
  localparam int         PAT_LEN = 4;

endpackage

// File: rtl/seq_detector.sv
// seq_detector: Mealy FSM that flags the serial pattern 1101 on input x.
//
// Ports:
//   x   - serial data bit, sampled on the rising edge of clk
//   clk - system clock
//   rst - synchronous active-high reset
//   z   - detect flag, high when the current x completes 1101
//
// Parameters:
//   OVERLAP - 1: the final "1" of a match also starts the next match
//             0: the FSM returns to idle after a match
//
// Configuration macro SEQ_DET_REG_OUT_EN:
//   defined   - z is registered, pulsing for one cycle after the edge
//               that captures the completing bit (glitch-free)
//   undefined - z is the combinational Mealy output (zero latency)
module seq_detector
  import seq_det_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic x,
  input  logic clk,
  input  logic rst,
  output logic z
);

  state_e state_q;
  state_e state_d;
  logic   hit;

  // The match completes when "110" has been seen and the final pattern
  // bit arrives on x.
  assign hit = (state_q == S3) && (x == PATTERN[0]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0: state_d = x ? S1 : S0;
      S1: state_d = x ? S2 : S0;
      // Extra 1s keep the "11" prefix alive.
      S2: state_d = x ? S2 : S3;
      // On a hit the trailing 1 can seed the next match.
      S3: begin
        if (x) begin
          state_d = OVERLAP ? S1 : S0;
        end else begin
          state_d = S0;
        end
      end
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SEQ_DET_REG_OUT_EN
  logic z_q;
  logic z_d;

  assign z_d = hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;
`else
  // Reset masks the flag immediately, even before the state is cleared.
  assign z = hit && !rst;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed self-checking bench for seq_detector.
// Two instances share the stimulus: one with OVERLAP=1, one with OVERLAP=0.
// Each slot drives x/rst just after a rising edge, checks z on the falling
// edge, then advances to the next rising edge.
module tb_seq_detector;

`ifdef SEQ_DET_REG_OUT_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  logic clk;
  logic rst;
  logic x;
  logic z_ov;
  logic z_no;

  int checks = 0;
  int errors = 0;

  seq_detector #(.OVERLAP(1'b1)) dut (
    .x   (x),
    .clk (clk),
    .rst (rst),
    .z   (z_ov)
  );

  seq_detector #(.OVERLAP(1'b0)) dut_no (
    .x   (x),
    .clk (clk),
    .rst (rst),
    .z   (z_no)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one slot's inputs and move to the sampling point.
  task automatic apply_stimulus(input logic xv, input logic rv);
    x   = xv;
    rst = rv;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit xs [3] = '{1, 0, 1};
    bit rs [3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(xs[i], rs[i]);
      checks++;
      if (z_ov !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_z slot %0d got %b expected 0", i, z_ov);
      end
      checks++;
      if (dut.state_q !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_state slot %0d got %b expected 00", i, dut.state_q);
      end
      next_edge();
    end
    // Last slot left x=1 in S0, so state is now S1.
    apply_stimulus(1'b0, 1'b0);
    checks++;
    if (dut.state_q !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_release_state got %b expected 01", dut.state_q);
    end
    next_edge();
  endtask

  task automatic test_basic();
    bit xs [6] = '{0, 1, 1, 0, 1, 0};
    bit rs [6] = '{1, 0, 0, 0, 0, 0};
    bit eo [6] = '{0, 0, 0, 0, 1, 0};
    bit en [6] = '{0, 0, 0, 0, 1, 0};
    logic po = 1'b0, pn = 1'b0, exo, exn;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(xs[i], rs[i]);
      exo = REG_OUT ? po : eo[i];
      exn = REG_OUT ? pn : en[i];
      checks++;
      if (z_ov !== exo) begin
        errors++;
        $display("[TB] FAIL basic_ov slot %0d got %b expected %b", i, z_ov, exo);
      end
      checks++;
      if (z_no !== exn) begin
        errors++;
        $display("[TB] FAIL basic_no slot %0d got %b expected %b", i, z_no, exn);
      end
      po = eo[i];
      pn = en[i];
      next_edge();
    end
  endtask

  task automatic test_overlap();
    bit xs [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 0};
    bit rs [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit eo [9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    bit en [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic po = 1'b0, pn = 1'b0, exo, exn;
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(xs[i], rs[i]);
      exo = REG_OUT ? po : eo[i];
      exn = REG_OUT ? pn : en[i];
      checks++;
      if (z_ov !== exo) begin
        errors++;
        $display("[TB] FAIL overlap_ov slot %0d got %b expected %b", i, z_ov, exo);
      end
      checks++;
      if (z_no !== exn) begin
        errors++;
        $display("[TB] FAIL overlap_no slot %0d got %b expected %b", i, z_no, exn);
      end
      po = eo[i];
      pn = en[i];
      next_edge();
    end
  endtask

  task automatic test_near_miss();
    // 1,1,1,0,1 then 1,0,1,0,1 separated by a reset slot.
    bit xs [13] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    bit rs [13] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    bit eo [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic po = 1'b0, exo;
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(xs[i], rs[i]);
      exo = REG_OUT ? po : eo[i];
      checks++;
      if (z_ov !== exo) begin
        errors++;
        $display("[TB] FAIL near_miss_ov slot %0d got %b expected %b", i, z_ov, exo);
      end
      checks++;
      if (z_no !== exo) begin
        errors++;
        $display("[TB] FAIL near_miss_no slot %0d got %b expected %b", i, z_no, exo);
      end
      po = eo[i];
      next_edge();
    end
  endtask

  task automatic test_mid_reset();
    // Reset arrives with x=1 while in S3: z must stay low and the
    // partial match must be forgotten.
    bit xs [7] = '{0, 1, 1, 0, 1, 1, 0};
    bit rs [7] = '{1, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(xs[i], rs[i]);
      checks++;
      if (z_ov !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_reset_ov slot %0d got %b expected 0", i, z_ov);
      end
      checks++;
      if (z_no !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_reset_no slot %0d got %b expected 0", i, z_no);
      end
      next_edge();
    end
  endtask

  task automatic test_leading_zero();
    bit xs [7] = '{0, 0, 1, 1, 0, 1, 0};
    bit rs [7] = '{1, 0, 0, 0, 0, 0, 0};
    bit eo [7] = '{0, 0, 0, 0, 0, 1, 0};
    logic po = 1'b0, exo;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(xs[i], rs[i]);
      exo = REG_OUT ? po : eo[i];
      checks++;
      if (z_ov !== exo) begin
        errors++;
        $display("[TB] FAIL leading_zero_ov slot %0d got %b expected %b", i, z_ov, exo);
      end
      checks++;
      if (z_no !== exo) begin
        errors++;
        $display("[TB] FAIL leading_zero_no slot %0d got %b expected %b", i, z_no, exo);
      end
      po = eo[i];
      next_edge();
    end
  endtask

  initial begin
    rst = 1'b1;
    x   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overlap();
    test_near_miss();
    test_mid_reset();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Serial bit-stream pattern detector. Watches single-bit input x and asserts z when the last four sampled bits, including the current x, equal 1101 (oldest first).
- Mealy finite-state machine. Sits on a serial data line in the gate-level power-estimation flow and is the target block for switching-activity dumps.

Parameters:
- OVERLAP, 1: 1 means overlapping detection (the trailing "1" of a match starts the next match); 0 means the FSM returns to idle after a match.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous to clk, active-high.
- x    input  1  serial data bit; sampled on the rising clk edge.
- z    output 1  detect flag; 1 when the current x completes 1101.
- Port order in the module header: x, clk, rst, z (positional instantiation depends on it).

Behaviour:
- One clock; reset is synchronous and active-high.
- States (2-bit encoding): S0=00 (nothing matched), S1=01 ("1"), S2=10 ("11"), S3=11 ("110").
- Reset: on a rising edge with rst=1, state goes to S0. z is forced to 0 whenever rst=1, regardless of x.
- Transitions on a rising edge with rst=0:
  - S0: x=1 goes to S1; x=0 stays in S0.
  - S1: x=1 goes to S2; x=0 goes to S0.
  - S2: x=1 stays in S2; x=0 goes to S3.
  - S3: x=1 goes to S1 when OVERLAP=1, or to S0 when OVERLAP=0; x=0 goes to S0.
- Output (Mealy, combinational): z = (state==S3) && (x==1) && !rst.
  - z rises in the same cycle the completing 1 is presented, before the capturing edge. Zero-cycle latency from x.
  - z is glitch-tolerant only; downstream logic samples it on clk.
- x=X/Z: state is unspecified until a known value is sampled. After reset, state is always known.
- Reset mid-sequence: the partial match is discarded and the next bit is evaluated from S0.
- No handshake; one bit is consumed on every clock edge.
- Next-state logic is one combinational block, the state register is one sequential block, and the output is one continuous assignment.

Optional Feature:
- Macro SEQ_DET_REG_OUT_EN.
- Defined: z is registered. On each edge z <= (state==S3 && x==1), and rst=1 clears z to 0. A detection appears on z for exactly one cycle, starting one edge after the completing bit is sampled. z then behaves like a Moore output and is glitch-free.
- Not defined: combinational Mealy z as described in Behaviour.

Decomposition:
- Shared package seq_det_pkg holds:
  - state typedef/localparams S0..S3 (2-bit);
  - localparam PATTERN = 4'b1101;
  - localparam PAT_LEN = 4.
- No sub-module is needed; a single FSM module is sufficient.

Test Plan:
- Reset: rst=1 for 2 edges while x toggles -> z=0 throughout, state=S0 after the first edge.
- Basic detect: after reset, x=1,1,0,1 on consecutive edges -> z=1 while the 4th bit is applied, z=0 at all other times. With SEQ_DET_REG_OUT_EN, z=1 for one cycle after the 4th edge.
- Overlap: x=1,1,0,1,1,0,1 -> with OVERLAP=1, z pulses twice (bits 4 and 7); with OVERLAP=0, z pulses once (bit 4 only).
- Near misses: x=1,1,1,0,1 -> one pulse at bit 5 (S2 self-loop); x=1,0,1,0,1 -> z never asserts.
- Mid-sequence reset: x=1,1,0, then rst=1 for one edge, then x=1 -> z=0 (the partial match was discarded).
- Leading zero: x=0,1,1,0,1, with rst released at the first edge -> z=1 during the 5th bit only.
